sram_req_arbiter: RTL

Two-to-one arbiter sharing the single sram-like data-bus master port between the instruction-fetch requester (IF) and the data-access requester (MEM/EXE load/store path). It grants one request per handshake, holds the grant stable until the slave accepts the address, and records the requester of every accepted transaction in an in-order ID FIFO so that each `data_ok`/`rdata` is returned to the correct stage. It sits between the pipeline's sram-like ports and the AXI bridge.

---
 rtl/sram_req_arbiter_pkg.sv | 23 ++
 rtl/sram_req_arbiter_id_fifo.sv | 58 +++++
 rtl/sram_req_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// rtl/sram_req_arbiter_pkg.sv - shared IDs, size encodings and grant helper for the sram-like arbiter
package sram_req_arbiter_pkg;

  typedef logic arb_id_t;

  localparam arb_id_t ARB_ID_INST = 1'b0;
  localparam arb_id_t ARB_ID_DATA = 1'b1;

  typedef enum logic [1:0] {
    SRAM_SIZE_BYTE = 2'd0,
    SRAM_SIZE_HALF = 2'd1,
    SRAM_SIZE_WORD = 2'd2
  } sram_size_e;

  // A held lock pins the grant; otherwise the data side has fixed priority.
  function automatic arb_id_t grant_sel(input logic    lock_valid,
                                        input arb_id_t lock_id,
                                        input logic    data_req);
    if (lock_valid) return lock_id;
    return data_req ? ARB_ID_DATA : ARB_ID_INST;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_id_fifo.sv
// rtl/sram_req_arbiter_id_fifo.sv - in-order requester ID FIFO for accepted transactions
module arb_id_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push_i,
  input  arb_id_t push_id_i,
  input  logic    pop_i,
  output arb_id_t head_o,
  output logic    empty_o,
  output logic    full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  arb_id_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= ARB_ID_INST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= push_id_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-to-one sram-like arbiter (IF vs data) with in-order response routing
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,

  output logic        err_unexp_data_ok
);

  logic    lock_valid_q, lock_valid_d;
  arb_id_t lock_id_q, lock_id_d;
  logic    err_q, err_d;

  arb_id_t gsel;
  arb_id_t fifo_head;
  logic    fifo_empty, fifo_full;
  logic    hs, pop;

  assign gsel  = grant_sel(lock_valid_q, lock_id_q, data_req);
  assign m_req = (lock_valid_q | inst_req | data_req) & ~fifo_full;
  assign hs    = m_req & m_addr_ok;
  assign pop   = m_data_ok & ~fifo_empty;

  assign m_wr    = (gsel == ARB_ID_DATA) ? data_wr    : inst_wr;
  assign m_size  = (gsel == ARB_ID_DATA) ? data_size  : inst_size;
  assign m_addr  = (gsel == ARB_ID_DATA) ? data_addr  : inst_addr;
  assign m_wdata = (gsel == ARB_ID_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = hs & (gsel == ARB_ID_INST);
  assign data_addr_ok = hs & (gsel == ARB_ID_DATA);

  // Read data is broadcast; only the completion strobe is steered by the FIFO head.
  assign inst_data_ok = pop & (fifo_head == ARB_ID_INST);
  assign data_data_ok = pop & (fifo_head == ARB_ID_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  assign err_unexp_data_ok = err_q;

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    err_d        = err_q | (m_data_ok & fifo_empty);
    if (hs) begin
      lock_valid_d = 1'b0;
    end else if (m_req) begin
      lock_valid_d = 1'b1;
      lock_id_d    = gsel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= ARB_ID_INST;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      err_q        <= err_d;
    end
  end

  arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (hs),
    .push_id_i(gsel),
    .pop_i    (pop),
    .head_o   (fifo_head),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full)
  );

endmodule
